// File: rtl/ps_xb_pkg.sv
// Shared sizing and compute-unit index constants
// for the crossbar register file.
package ps_xb_pkg;
    localparam int XB_WRT  = 16;
    localparam int XB_NREG = 16;
    localparam int XB_AW   = 4;
    localparam int XB_NCU  = 3;

    localparam int CU_ALU = 0;
    localparam int CU_MUL = 1;
    localparam int CU_SHF = 2;
endpackage

// File: rtl/xb_wr_arb.sv
// Compute-unit write arbiter: fixed-priority data
// select (ALU > MUL > SHF) and multi-writer detect.
module xb_wr_arb
    import ps_xb_pkg::*;
#(
    parameter int wrt = XB_WRT
) (
    input  logic [XB_NCU-1:0] cu_en,
    input  logic [wrt-1:0]    alu_res,
    input  logic [wrt-1:0]    mul_res,
    input  logic [wrt-1:0]    shf_res,
    output logic              wr_act,
    output logic [wrt-1:0]    wr_data,
    output logic              conflict
);
    logic a, m, s;

    assign a = cu_en[CU_ALU];
    assign m = cu_en[CU_MUL];
    assign s = cu_en[CU_SHF];

    assign wr_act   = a | m | s;
    assign conflict = (a & m) | (a & s) | (m & s);

    always_comb begin
        wr_data = '0;
        priority case (1'b1)
            a:       wr_data = alu_res;
            m:       wr_data = mul_res;
            s:       wr_data = shf_res;
            default: wr_data = '0;
        endcase
    end
endmodule

// File: rtl/xb_regfile.sv
// Crossbar register file: two zero-latency read ports
// with write bypass, one CU write port and a load port.
module xb_regfile
    import ps_xb_pkg::*;
#(
    parameter int wrt  = XB_WRT,
    parameter int NREG = XB_NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XB_AW-1:0]  ps_xb_rd_a0,
    input  logic [XB_AW-1:0]  ps_xb_raddy,
    input  logic [XB_AW-1:0]  ps_xb_wrt_a,
    input  logic [XB_NCU-1:0] ps_xb_w_cuEn,
    input  logic [wrt-1:0]    alu_res,
    input  logic [wrt-1:0]    mul_res,
    input  logic [wrt-1:0]    shf_res,
    input  logic              ld_req,
    input  logic [XB_AW-1:0]  ld_a,
    input  logic [wrt-1:0]    ld_d,
    output logic              ld_ack,
    output logic [wrt-1:0]    xb_dt_x,
    output logic [wrt-1:0]    xb_dt_y,
    input  logic              err_clr,
    output logic              xb_wr_err
);
    logic [wrt-1:0]   rf [NREG];
    logic [XB_AW-1:0] wa_q;
    logic             wr_act;
    logic             conflict;
    logic [wrt-1:0]   wr_data;
    logic             ld_go;

    xb_wr_arb #(.wrt(wrt)) u_arb (
        .cu_en    (ps_xb_w_cuEn),
        .alu_res  (alu_res),
        .mul_res  (mul_res),
        .shf_res  (shf_res),
        .wr_act   (wr_act),
        .wr_data  (wr_data),
        .conflict (conflict)
    );

    // CU writes own the port; a pending load waits for an idle cycle
    assign ld_go = ld_req & ~wr_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            wa_q      <= '0;
            ld_ack    <= 1'b0;
            xb_wr_err <= 1'b0;
        end else begin
            wa_q   <= ps_xb_wrt_a;
            ld_ack <= ld_go;
            if (wr_act)
                rf[wa_q] <= wr_data;
            else if (ld_req)
                rf[ld_a] <= ld_d;
            // a fresh conflict wins over a clear in the same cycle
            if (conflict)
                xb_wr_err <= 1'b1;
            else if (err_clr)
                xb_wr_err <= 1'b0;
        end
    end

    always_comb begin
        xb_dt_x = rf[ps_xb_rd_a0];
        xb_dt_y = rf[ps_xb_raddy];
        if (wr_act && ps_xb_rd_a0 == wa_q) xb_dt_x = wr_data;
        if (wr_act && ps_xb_raddy == wa_q) xb_dt_y = wr_data;
        if (rst) begin
            xb_dt_x = '0;
            xb_dt_y = '0;
        end
    end
endmodule

// File: tb/tb_xb_regfile.sv
// Directed bench for xb_regfile: bypass, priority,
// sticky error, load stall and reset behaviour.
module tb_xb_regfile;
    logic        clk;
    logic        rst;
    logic [3:0]  rd_a0, raddy, wrt_a;
    logic [2:0]  cu_en;
    logic [15:0] alu, mul, shf;
    logic        ld_req;
    logic [3:0]  ld_a;
    logic [15:0] ld_d;
    logic        ld_ack;
    logic [15:0] dt_x, dt_y;
    logic        err_clr;
    logic        wr_err;

    int n_chk;
    int n_fail;

    xb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .ps_xb_rd_a0  (rd_a0),
        .ps_xb_raddy  (raddy),
        .ps_xb_wrt_a  (wrt_a),
        .ps_xb_w_cuEn (cu_en),
        .alu_res      (alu),
        .mul_res      (mul),
        .shf_res      (shf),
        .ld_req       (ld_req),
        .ld_a         (ld_a),
        .ld_d         (ld_d),
        .ld_ack       (ld_ack),
        .xb_dt_x      (dt_x),
        .xb_dt_y      (dt_y),
        .err_clr      (err_clr),
        .xb_wr_err    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        rd_a0 = 0; raddy = 0; wrt_a = 0; cu_en = 0;
        alu = 0; mul = 0; shf = 0;
        ld_req = 0; ld_a = 0; ld_d = 0; err_clr = 0;
        #2;
        chk("rst_x", dt_x, 16'h0);
        chk("rst_y", dt_y, 16'h0);
        chk("rst_ack", {15'b0, ld_ack}, 16'h0);
        chk("rst_err", {15'b0, wr_err}, 16'h0);
        tick();
        rst = 1'b0;

        // ALU write to r5 with bypass
        wrt_a = 5;
        tick();
        cu_en = 3'b001; alu = 16'h1234; rd_a0 = 5; wrt_a = 0;
        #1 chk("byp_r5", dt_x, 16'h1234);
        tick();
        cu_en = 0;
        #1 chk("rf_r5", dt_x, 16'h1234);

        // ALU+MUL conflict on r3
        wrt_a = 3;
        tick();
        cu_en = 3'b011; alu = 16'hAAAA; mul = 16'h5555; rd_a0 = 3;
        wrt_a = 0;
        #1 chk("byp_r3", dt_x, 16'hAAAA);
        chk("err_pre", {15'b0, wr_err}, 16'h0);
        tick();
        cu_en = 0;
        #1 chk("rf_r3", dt_x, 16'hAAAA);
        chk("err_set", {15'b0, wr_err}, 16'h1);
        tick();
        chk("err_hold", {15'b0, wr_err}, 16'h1);
        err_clr = 1;
        tick();
        err_clr = 0;
        #1 chk("err_clr", {15'b0, wr_err}, 16'h0);

        // load stalled by two shifter writes to r1
        wrt_a = 1;
        tick();
        cu_en = 3'b100; shf = 16'h0F0F; wrt_a = 1;
        ld_req = 1; ld_a = 7; ld_d = 16'hBEEF;
        tick();
        chk("ld_stall1", {15'b0, ld_ack}, 16'h0);
        wrt_a = 0;
        tick();
        cu_en = 0; rd_a0 = 7;
        #1 chk("ld_stall2", {15'b0, ld_ack}, 16'h0);
        chk("ld_nobyp", dt_x, 16'h0);
        tick();
        chk("ld_ack", {15'b0, ld_ack}, 16'h1);
        chk("rf_r7", dt_x, 16'hBEEF);
        ld_req = 0;
        raddy = 1;
        #1 chk("rf_r1", dt_y, 16'h0F0F);
        tick();
        chk("ld_ack_pls", {15'b0, ld_ack}, 16'h0);

        // back-to-back writes to r9
        wrt_a = 9; raddy = 9;
        tick();
        cu_en = 3'b001; alu = 16'h0001;
        #1 chk("r9_w1", dt_y, 16'h0001);
        tick();
        alu = 16'h0002; wrt_a = 0;
        #1 chk("r9_w2", dt_y, 16'h0002);
        tick();
        cu_en = 0;
        #1 chk("rf_r9", dt_y, 16'h0002);

        // address 0 is an ordinary register
        wrt_a = 0; raddy = 0;
        tick();
        cu_en = 3'b001; alu = 16'h00A0;
        tick();
        cu_en = 0;
        #1 chk("rf_r0", dt_y, 16'h00A0);

        // conflict, then clear coinciding with a new conflict
        wrt_a = 4;
        tick();
        cu_en = 3'b011; alu = 16'h1111; mul = 16'h2222; wrt_a = 6;
        tick();
        chk("err_set2", {15'b0, wr_err}, 16'h1);
        cu_en = 3'b110; mul = 16'h6666; shf = 16'h7777; err_clr = 1;
        wrt_a = 0;
        tick();
        cu_en = 0; err_clr = 0; rd_a0 = 6;
        #1 chk("err_keep", {15'b0, wr_err}, 16'h1);
        chk("rf_r6_mul", dt_x, 16'h6666);
        rd_a0 = 4;
        #1 chk("rf_r4_alu", dt_x, 16'h1111);
        err_clr = 1;
        tick();
        err_clr = 0;
        #1 chk("err_clr2", {15'b0, wr_err}, 16'h0);

        // r2=FFFF with conflict, then reset during a stalled load
        wrt_a = 2;
        tick();
        cu_en = 3'b011; alu = 16'hFFFF; mul = 16'h0000; wrt_a = 8;
        tick();
        cu_en = 3'b001; alu = 16'h3333;
        ld_req = 1; ld_a = 2; ld_d = 16'hCAFE; rd_a0 = 2; raddy = 5;
        #1 chk("rf_r2", dt_x, 16'hFFFF);
        chk("err_prerst", {15'b0, wr_err}, 16'h1);
        #1 rst = 1;
        #1 chk("mrst_x", dt_x, 16'h0);
        chk("mrst_y", dt_y, 16'h0);
        chk("mrst_ack", {15'b0, ld_ack}, 16'h0);
        chk("mrst_err", {15'b0, wr_err}, 16'h0);
        tick();
        rst = 0; ld_req = 0; cu_en = 0;
        #1 chk("prst_r2", dt_x, 16'h0);
        chk("prst_r5", dt_y, 16'h0);
        tick();
        chk("prst_ack", {15'b0, ld_ack}, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
